// File: rtl/register_bank_mp.sv
// register_bank_mp: multi-read, dual-write register bank with a per-register
// busy scoreboard. Write port 1 (load writeback) beats write port 0 (ALU
// writeback) on an address collision. Optional same-cycle write-to-read
// bypass and optional registered read outputs.

module register_bank_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int READ_REG = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr0_en,
    input  logic [ADDR_W-1:0]        wr0_addr,
    input  logic [DATA_W-1:0]        wr0_data,
    input  logic                     wr1_en,
    input  logic [ADDR_W-1:0]        wr1_addr,
    input  logic [DATA_W-1:0]        wr1_data,
    input  logic                     busy_set_en,
    input  logic [ADDR_W-1:0]        busy_set_addr,
    output logic                     any_busy
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0]        regs [DEPTH];
    logic [DEPTH-1:0]         busy;
    logic [DEPTH-1:0]         busy_set_vec;
    logic [DEPTH-1:0]         busy_clr_vec;
    logic [DEPTH-1:0]         busy_next;
    logic [NUM_RD*DATA_W-1:0] eff_data;
    logic [NUM_RD-1:0]        eff_busy;
    logic                     wr0_ok;
    logic                     wr1_ok;
    logic                     set_ok;

    // Writes and issues to the hard-wired zero register are dropped here so
    // that storage, bypass and scoreboard all see the same filtered request.
    assign wr0_ok = wr0_en && !((ZERO_REG != 0) && (wr0_addr == '0));
    assign wr1_ok = wr1_en && !((ZERO_REG != 0) && (wr1_addr == '0));
    assign set_ok = busy_set_en && !((ZERO_REG != 0) && (busy_set_addr == '0));

    // Decode this cycle's scoreboard set/clear; set wins over clear because
    // it represents a newly issued producer.
    always_comb begin
        busy_set_vec = '0;
        busy_clr_vec = '0;
        if (set_ok) busy_set_vec[busy_set_addr] = 1'b1;
        if (wr0_ok) busy_clr_vec[wr0_addr] = 1'b1;
        if (wr1_ok) busy_clr_vec[wr1_addr] = 1'b1;
        busy_next = (busy & ~busy_clr_vec) | busy_set_vec;
    end

    // Register array; wr1 is assigned last so it wins on a shared address.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else begin
            if (wr0_ok) regs[wr0_addr] <= wr0_data;
            if (wr1_ok) regs[wr1_addr] <= wr1_data;
        end
    end

    // Busy scoreboard state.
    always_ff @(posedge clk) begin
        if (reset) busy <= '0;
        else       busy <= busy_next;
    end

    assign any_busy = |busy;

    for (genvar p = 0; p < NUM_RD; p++) begin : g_port
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rv;

        assign ra = rd_addr[p*ADDR_W +: ADDR_W];

        // Effective read value: bypass from wr1 over wr0 over array, with the
        // zero register forced to 0 last so bypass cannot leak into it.
        always_comb begin
            rv = regs[ra];
            if (BYPASS != 0) begin
                if (wr0_ok && (wr0_addr == ra)) rv = wr0_data;
                if (wr1_ok && (wr1_addr == ra)) rv = wr1_data;
            end
            if ((ZERO_REG != 0) && (ra == '0)) rv = '0;
        end

        assign eff_data[p*DATA_W +: DATA_W] = rv;
        assign eff_busy[p] = (BYPASS != 0) ? busy_next[ra] : busy[ra];
    end

    if (READ_REG != 0) begin : g_rd_reg
        // Registered read outputs: address in cycle N, data in cycle N+1.
        always_ff @(posedge clk) begin
            if (reset) begin
                rd_data <= '0;
                rd_busy <= '0;
            end else begin
                rd_data <= eff_data;
                rd_busy <= eff_busy;
            end
        end
    end else begin : g_rd_comb
        assign rd_data = eff_data;
        assign rd_busy = eff_busy;
    end

endmodule
